// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder/decoder helpers.
// Width rounding for pixel streams, the level shift applied to DCT-domain
// pixels, and the number of 8x8 blocks per line of the frame.
package jpeg_enc_pkg;

  localparam int unsigned BLOCK_DIM = 8;

  // Pixel stream TDATA width: PX_WIDTH rounded up to whole bytes.
  function automatic int unsigned px_tdata_width(input int unsigned px_width);
    return ((px_width + 7) / 8) * 8;
  endfunction

  // Offset between the signed DCT-domain range and unsigned pixel range.
  function automatic int unsigned value_shift(input int unsigned px_width);
    return 32'd1 << (px_width - 1);
  endfunction

  // 8x8 blocks across one line of the frame.
  function automatic int unsigned blocks_per_line(input int unsigned res_x);
    return res_x / BLOCK_DIM;
  endfunction

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle.
//   master: drives tvalid/tdata/tlast/tuser, receives tready
//   slave : receives tvalid/tdata/tlast/tuser, drives tready
interface axi4_stream_if #(
  parameter int unsigned TDATA_WIDTH = 8,
  parameter int unsigned TUSER_WIDTH = 1
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;
  logic                   tlast;
  logic [TUSER_WIDTH-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/block_stripe_ram.sv
// Simple dual-port stripe buffer with a 1-cycle registered read.
//   clk_i   : clock
//   wr_en   : write strobe, wr_addr/wr_data
//   rd_en   : read strobe, rd_addr; rd_data valid the cycle after rd_en
// The address MSB selects the bank; DEPTH only needs to reach the last
// word of the upper bank. Contents are never reset.
module block_stripe_ram #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 2560
) (
  input  logic              clk_i,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/dct_to_px_adapter.sv
// Converts block-ordered IDCT rows (one 8-pixel row per beat) into a raster
// pixel stream, one pixel per beat, through a ping-pong stripe buffer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   par_video_i  : slave, TDATA = PX_WIDTH*8, signed level-shifted pixels
//   ser_video_o  : master, TDATA = PX_WIDTH rounded to bytes, unsigned
//                  pixels, tlast at end of line, tuser on frame start
module dct_to_px_adapter
  import jpeg_enc_pkg::*;
#(
  parameter int unsigned PX_WIDTH    = 8,
  parameter int unsigned FRAME_RES_X = 1280
) (
  input  logic          clk_i,
  input  logic          rst_i,
  axi4_stream_if.slave  par_video_i,
  axi4_stream_if.master ser_video_o
);
  localparam int unsigned BPL    = blocks_per_line(FRAME_RES_X);
  localparam int unsigned WORDS  = BPL * BLOCK_DIM;
  localparam int unsigned AW     = $clog2(WORDS);
  localparam int unsigned BW     = (BPL > 1) ? $clog2(BPL) : 1;
  localparam int unsigned XW     = $clog2(FRAME_RES_X);
  localparam int unsigned ROW_W  = PX_WIDTH * BLOCK_DIM;
  localparam int unsigned TDW    = px_tdata_width(PX_WIDTH);
  localparam int unsigned VSHIFT = value_shift(PX_WIDTH);

  // ---------------- write side ----------------
  logic [2:0]    wr_row;
  logic [BW-1:0] wr_blk;
  logic          wr_bank;
  logic [1:0]    full, full_next, user_flag;
  logic          in_ready, wr_en, wr_at_origin, wr_resync, wr_stripe_done;
  logic [AW-1:0] wr_word;

  assign in_ready             = !rst_i && !full[wr_bank];
  assign par_video_i.tready   = in_ready;
  assign wr_en                = in_ready && par_video_i.tvalid;
  assign wr_at_origin         = (wr_row == '0) && (wr_blk == '0);
  assign wr_resync            = par_video_i.tuser[0] && !wr_at_origin;
  assign wr_word              = wr_resync ? '0 : AW'(32'(wr_row) * BPL + 32'(wr_blk));
  assign wr_stripe_done       = !wr_resync && (wr_row == 3'd7) && (wr_blk == BW'(BPL - 1));

  // ---------------- read side ----------------
  logic [2:0]       rd_line;
  logic [XW-1:0]    rd_x;
  logic             rd_bank, rd_issue, rd_x_last, rd_bank_last;
  logic [AW-1:0]    rd_word;
  logic             rd_vld_q, rd_last_q, rd_user_q, rd_end_q;
  logic [2:0]       rd_sel_q;
  logic [ROW_W-1:0] ram_rdata;
  logic [PX_WIDTH-1:0] rd_px;

  // 2-entry output queue absorbing the RAM read latency under backpressure
  logic [PX_WIDTH-1:0] q_data [2];
  logic [1:0] q_last, q_user, q_end;
  logic       q_wp, q_rp, clr_bank, ser_valid, pop, full_clr;
  logic [1:0] q_cnt, occ;

  assign ser_valid    = !rst_i && (q_cnt != '0);
  assign pop          = ser_valid && ser_video_o.tready;
  assign full_clr     = pop && q_end[q_rp];
  // Issue only if the read in flight plus the queue cannot overflow after
  // this cycle's pop; keeps one pixel per cycle in steady state.
  assign occ          = q_cnt + 2'(rd_vld_q) - 2'(pop);
  assign rd_issue     = full[rd_bank] && (occ <= 2'd1);
  assign rd_x_last    = (rd_x == XW'(FRAME_RES_X - 1));
  assign rd_bank_last = rd_x_last && (rd_line == 3'd7);
  assign rd_word      = AW'(32'(rd_line) * BPL + 32'(rd_x) / 8);
  assign rd_px        = ram_rdata[32'(rd_sel_q) * PX_WIDTH +: PX_WIDTH] + PX_WIDTH'(VSHIFT);

  assign ser_video_o.tvalid = ser_valid;
  assign ser_video_o.tdata  = ser_valid ? TDW'(q_data[q_rp]) : '0;
  assign ser_video_o.tlast  = ser_valid && q_last[q_rp];
  assign ser_video_o.tuser  = ser_valid && q_user[q_rp];

  // Set and clear always target different banks, so both apply in one cycle.
  always_comb begin
    full_next = full;
    if (full_clr) full_next[clr_bank] = 1'b0;
    if (wr_en && wr_stripe_done) full_next[wr_bank] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_row    <= '0;
      wr_blk    <= '0;
      wr_bank   <= 1'b0;
      full      <= '0;
      user_flag <= '0;
    end else begin
      full <= full_next;
      if (wr_en) begin
        if (wr_at_origin || wr_resync) user_flag[wr_bank] <= par_video_i.tuser[0];
        if (wr_resync) begin
          // Resync beat lands at word 0, so the next beat is row 1.
          wr_row <= 3'd1;
          wr_blk <= '0;
        end else if (wr_row == 3'd7) begin
          wr_row <= '0;
          if (wr_blk == BW'(BPL - 1)) begin
            wr_blk  <= '0;
            wr_bank <= ~wr_bank;
          end else begin
            wr_blk <= wr_blk + 1'b1;
          end
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_line   <= '0;
      rd_x      <= '0;
      rd_bank   <= 1'b0;
      rd_vld_q  <= 1'b0;
      rd_sel_q  <= '0;
      rd_last_q <= 1'b0;
      rd_user_q <= 1'b0;
      rd_end_q  <= 1'b0;
    end else begin
      rd_vld_q <= rd_issue;
      if (rd_issue) begin
        rd_sel_q  <= rd_x[2:0];
        rd_last_q <= rd_x_last;
        rd_user_q <= user_flag[rd_bank] && (rd_line == 3'd0) && (rd_x == '0);
        rd_end_q  <= rd_bank_last;
        if (rd_x_last) begin
          rd_x <= '0;
          if (rd_line == 3'd7) begin
            rd_line <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            rd_line <= rd_line + 1'b1;
          end
        end else begin
          rd_x <= rd_x + 1'b1;
        end
      end
    end
  end

  // Bank release follows acceptance of its final pixel, not the read issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_cnt    <= '0;
      q_wp     <= 1'b0;
      q_rp     <= 1'b0;
      clr_bank <= 1'b0;
    end else begin
      if (rd_vld_q) begin
        q_data[q_wp] <= rd_px;
        q_last[q_wp] <= rd_last_q;
        q_user[q_wp] <= rd_user_q;
        q_end[q_wp]  <= rd_end_q;
        q_wp         <= ~q_wp;
      end
      if (pop) q_rp <= ~q_rp;
      if (full_clr) clr_bank <= ~clr_bank;
      q_cnt <= occ;
    end
  end

  block_stripe_ram #(
    .WIDTH  (ROW_W),
    .ADDR_W (AW + 1),
    .DEPTH  ((1 << AW) + WORDS)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr ({wr_bank, wr_word}),
    .wr_data (par_video_i.tdata),
    .rd_en   (rd_issue),
    .rd_addr ({rd_bank, rd_word}),
    .rd_data (ram_rdata)
  );
endmodule

// File: tb/tb_dct_to_px_adapter.sv
// Bench for dct_to_px_adapter: a 16-pixel-wide instance driven through
// directed and randomized stripes, plus an 8-pixel-wide (single block per
// line) instance streaming continuously.
module tb_dct_to_px_adapter;
  localparam int unsigned RES  = 16;
  localparam int unsigned RES2 = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  axi4_stream_if #(.TDATA_WIDTH(64), .TUSER_WIDTH(1)) in_if ();
  axi4_stream_if #(.TDATA_WIDTH(8),  .TUSER_WIDTH(1)) out_if ();
  axi4_stream_if #(.TDATA_WIDTH(64), .TUSER_WIDTH(1)) in2 ();
  axi4_stream_if #(.TDATA_WIDTH(8),  .TUSER_WIDTH(1)) out2 ();

  dct_to_px_adapter #(.PX_WIDTH(8), .FRAME_RES_X(RES)) u_dut (
    .clk_i(clk), .rst_i(rst), .par_video_i(in_if), .ser_video_o(out_if));

  dct_to_px_adapter #(.PX_WIDTH(8), .FRAME_RES_X(RES2)) u_dut8 (
    .clk_i(clk), .rst_i(rst2), .par_video_i(in2), .ser_video_o(out2));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] d; logic l; logic u; } px_t;
  px_t         exp_q[$];
  logic [63:0] beats[$];
  bit          stripe_user;

  // A stripe is 16 beats: beat b is row b%8 of block b/8. Once complete
  // it becomes 128 raster pixels, level-shifted by +128.
  task automatic model_beat(input logic [63:0] d, input bit u);
    logic [63:0] w;
    px_t e;
    if (u && beats.size() != 0) beats.delete();
    if (beats.size() == 0) stripe_user = u;
    beats.push_back(d);
    if (beats.size() == 16) begin
      for (int l = 0; l < 8; l++)
        for (int x = 0; x < int'(RES); x++) begin
          w   = beats[(x / 8) * 8 + l];
          e.d = 8'(int'(w[(x % 8) * 8 +: 8]) + 128);
          e.l = (x == int'(RES) - 1);
          e.u = stripe_user && l == 0 && x == 0;
          exp_q.push_back(e);
        end
      beats.delete();
    end
  endtask

  // ---------------- output ready driver ----------------
  int rdy_mode = 1;  // 0: hold low, 1: always high, 2: random 50%
  initial begin
    out_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_if.tready = 1'b0;
        1:       out_if.tready = 1'b1;
        default: out_if.tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- output monitor ----------------
  int   acc_cnt = 0;
  bit   hold = 0;
  logic [7:0] hdata;
  logic hlast, huser;
  initial begin
    px_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold = 0;
      end else begin
        if (hold) begin
          check("hold_valid", out_if.tvalid, 1);
          check("hold_data",  out_if.tdata,  hdata);
          check("hold_last",  out_if.tlast,  hlast);
          check("hold_user",  out_if.tuser,  huser);
        end
        if (out_if.tvalid && out_if.tready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            check("extra_px", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            check("px_data", out_if.tdata, e.d);
            check("px_last", out_if.tlast, e.l);
            check("px_user", out_if.tuser, e.u);
          end
        end
        hold  = out_if.tvalid && !out_if.tready;
        hdata = out_if.tdata;
        hlast = out_if.tlast;
        huser = out_if.tuser;
      end
    end
  end

  // ---------------- input driver ----------------
  task automatic send_beat(input logic [63:0] d, input bit u);
    int n = 0;
    in_if.tdata  = d;
    in_if.tuser  = u;
    in_if.tlast  = 1'($urandom_range(0, 1));
    in_if.tvalid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_if.tready && n < 3000);
    check("in_accept", in_if.tready, 1);
    @(posedge clk);
    if (in_if.tready) model_beat(d, u);
    #1;
    in_if.tvalid = 1'b0;
  endtask

  function automatic logic [63:0] ramp_beat(input int b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++)
      w[k * 8 +: 8] = 8'((b % 8) * 16 + (b / 8) * 8 + k + 128);
    return w;
  endfunction

  task automatic send_ramp_stripe();
    for (int b = 0; b < 16; b++) send_beat(ramp_beat(b), b == 0);
  endtask

  task automatic send_rand_beats(input int n, input bit first_user);
    for (int b = 0; b < n; b++) send_beat({$urandom, $urandom}, first_user && b == 0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
  endtask

  // ---------------- single-block-wide instance ----------------
  int o2 = 0;
  initial begin
    in2.tvalid = 1'b0; in2.tdata = '0; in2.tuser = 1'b0; in2.tlast = 1'b0;
    out2.tready = 1'b1;
    wait (!rst2);
    @(posedge clk); #1;
    for (int b = 0; b < 40; b++) begin
      int n = 0;
      for (int k = 0; k < 8; k++)
        in2.tdata[k * 8 +: 8] = 8'((b % 8) * 8 + k + (b / 8) * 7 + 128);
      in2.tuser  = (b == 0);
      in2.tvalid = 1'b1;
      do begin
        @(negedge clk);
        n++;
      end while (!in2.tready && n < 3000);
      @(posedge clk); #1;
    end
    in2.tvalid = 1'b0;
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst2 && out2.tvalid && out2.tready) begin
        check("bpl1_data", out2.tdata, 8'(((o2 % 64) / 8) * 8 + (o2 % 8) + (o2 / 64) * 7));
        check("bpl1_last", out2.tlast, (o2 % 8) == 7);
        check("bpl1_user", out2.tuser, o2 == 0);
        o2++;
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int start, n;
    bit seen;
    logic [63:0] w;
    in_if.tvalid = 1'b0; in_if.tdata = '0; in_if.tuser = 1'b0; in_if.tlast = 1'b0;

    // reset state
    repeat (2) @(negedge clk);
    check("rst_tvalid", out_if.tvalid, 0);
    check("rst_tready", in_if.tready, 0);
    check("rst_tdata",  out_if.tdata, 0);
    check("rst_tlast",  out_if.tlast, 0);
    check("rst_tuser",  out_if.tuser, 0);
    @(posedge clk); #1;
    rst = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    check("post_rst_tvalid", out_if.tvalid, 0);
    check("post_rst_tready", in_if.tready, 1);

    // ramp stripe: output 0..127, first pixel within 3 cycles of full
    rdy_mode = 1;
    send_ramp_stripe();
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_if.tvalid) seen = 1;
    end
    check("first_px_latency", seen, 1);
    drain("ramp_drain");

    // stall: two stripes with output held off
    @(posedge clk); rdy_mode = 0;
    repeat (3) @(posedge clk);
    send_rand_beats(16, 1);
    send_rand_beats(16, 0);
    @(negedge clk);
    check("stall_tready", in_if.tready, 0);
    repeat (5) @(negedge clk);
    @(posedge clk);
    rdy_mode = 1;
    #2;
    start = acc_cnt;
    repeat (256) @(posedge clk);
    #2;
    check("stall_burst", acc_cnt - start, 256);
    check("stall_empty", exp_q.size(), 0);

    // random backpressure, including wrap values 0x7F / 0x80
    rdy_mode = 2;
    for (int k = 0; k < 8; k++) w[k * 8 +: 8] = (k % 2 == 0) ? 8'h7F : 8'h80;
    send_beat(w, 1);
    send_rand_beats(15, 0);
    send_rand_beats(32, 1);
    drain("random_drain");

    // resync on beat 5
    rdy_mode = 1;
    send_rand_beats(5, 1);
    send_rand_beats(16, 1);
    drain("resync_drain");

    // reset during readout
    send_ramp_stripe();
    start = acc_cnt;
    n = 0;
    while (acc_cnt - start < 20 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("pre_rst_progress", acc_cnt - start >= 20, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    beats.delete();
    @(negedge clk);
    check("midrst_tvalid", out_if.tvalid, 0);
    check("midrst_tready", in_if.tready, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    send_ramp_stripe();
    drain("after_rst_drain");

    // single-block-wide instance: five stripes
    n = 0;
    while (o2 < 320 && n < 10000) begin
      @(posedge clk);
      n++;
    end
    check("bpl1_count", o2, 320);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
